// File: rtl/ext_input_conditioner_pkg.sv
// Shared field layout and timing helpers for the external-input conditioner.
// Other timing blocks reuse calc_debounce_cycles so every debounce window is derived the same way.
package ext_input_package;

    localparam int EXT_LEVEL_LSB  = 0;
    localparam int EXT_RISE_LSB   = 8;
    localparam int EXT_FALL_LSB   = 16;
    localparam int EXT_RAW_LSB    = 24;
    localparam int EXT_MAX_INPUTS = 8;

    // Whole-MHz truncation is intentional; never returns less than one cycle.
    function automatic int calc_debounce_cycles(input int clk_hz, input int window_us);
        int cycles;
        cycles = (clk_hz / 1000000) * window_us;
        return (cycles < 1) ? 1 : cycles;
    endfunction

endpackage

// File: rtl/ext_input_conditioner_debounce.sv
// One input channel: 2-flop synchronizer, saturating debounce counter, debounced level and registered edge pulses.
// Level follows a clean pin change 2+DEBOUNCE_CYCLES clocks after first sampling; no backpressure (free-running).
module ext_debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic pin_i,
    output logic sync_o,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        sync1_d = pin_i;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        // Any sample that agrees with the current level restarts the window, so glitches never accumulate.
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
            rise_d  = sync2_q;
            fall_d  = ~sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sync_o  = sync2_q;
    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ext_input_conditioner.sv
// Conditions raw board inputs into debounced levels plus firmware-cleared sticky edge flags, packed for the CPU bus.
// Flags appear one clock after the level changes; no backpressure (flags hold until clear_i or reset).
module ext_input_conditioner
    import ext_input_package::*;
#(
    parameter int NUM_INPUTS   = 8,
    parameter int FPGAClkSpeed = 40000000,
    parameter int DEBOUNCE_US  = 1000
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [NUM_INPUTS-1:0] pins_i,
    input  logic [NUM_INPUTS-1:0] clear_i,
    output logic [NUM_INPUTS-1:0] level_o,
    output logic [NUM_INPUTS-1:0] rise_o,
    output logic [NUM_INPUTS-1:0] fall_o,
    output logic                  event_o,
    output logic [31:0]           data_o
);

    localparam int DEBOUNCE_CYCLES = calc_debounce_cycles(FPGAClkSpeed, DEBOUNCE_US);

    logic [NUM_INPUTS-1:0] raw;
    logic [NUM_INPUTS-1:0] level;
    logic [NUM_INPUTS-1:0] rise_pulse;
    logic [NUM_INPUTS-1:0] fall_pulse;
    logic [NUM_INPUTS-1:0] rise_q, rise_d;
    logic [NUM_INPUTS-1:0] fall_q, fall_d;

    for (genvar n = 0; n < NUM_INPUTS; n++) begin : g_chan
        ext_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk_i  (clk_i),
            .reset_i(reset_i),
            .pin_i  (pins_i[n]),
            .sync_o (raw[n]),
            .level_o(level[n]),
            .rise_o (rise_pulse[n]),
            .fall_o (fall_pulse[n])
        );
    end

    // Set is OR-ed in after the clear mask so a same-cycle edge is never lost.
    always_comb begin
        rise_d = (rise_q & ~clear_i) | rise_pulse;
        fall_d = (fall_q & ~clear_i) | fall_pulse;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    logic [EXT_MAX_INPUTS-1:0] level8, rise8, fall8, raw8;

    always_comb begin
        level8 = '0;
        rise8  = '0;
        fall8  = '0;
        raw8   = '0;
        level8[NUM_INPUTS-1:0] = level;
        rise8[NUM_INPUTS-1:0]  = rise_q;
        fall8[NUM_INPUTS-1:0]  = fall_q;
        raw8[NUM_INPUTS-1:0]   = raw;
        data_o = '0;
        data_o[EXT_LEVEL_LSB +: EXT_MAX_INPUTS] = level8;
        data_o[EXT_RISE_LSB  +: EXT_MAX_INPUTS] = rise8;
        data_o[EXT_FALL_LSB  +: EXT_MAX_INPUTS] = fall8;
        data_o[EXT_RAW_LSB   +: EXT_MAX_INPUTS] = raw8;
    end

    assign level_o = level;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign event_o = (|rise_q) | (|fall_q);

endmodule

// File: tb/tb_ext_input_conditioner.sv
// Directed bench for ext_input_conditioner at 1 MHz / 4 us (4-cycle debounce window), plus a 3-input build.
module tb_ext_input_conditioner;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  pins, clear;
    logic [7:0]  level, rise, fall;
    logic        evt;
    logic [31:0] data;

    logic [2:0]  pins3, clear3;
    logic [2:0]  level3, rise3, fall3;
    logic        evt3;
    logic [31:0] data3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ext_input_conditioner #(
        .NUM_INPUTS(8), .FPGAClkSpeed(1000000), .DEBOUNCE_US(4)
    ) dut (
        .clk_i(clk), .reset_i(reset_n), .pins_i(pins), .clear_i(clear),
        .level_o(level), .rise_o(rise), .fall_o(fall), .event_o(evt), .data_o(data)
    );

    ext_input_conditioner #(
        .NUM_INPUTS(3), .FPGAClkSpeed(1000000), .DEBOUNCE_US(4)
    ) dut3 (
        .clk_i(clk), .reset_i(reset_n), .pins_i(pins3), .clear_i(clear3),
        .level_o(level3), .rise_o(rise3), .fall_o(fall3), .event_o(evt3), .data_o(data3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        pins    = 8'hFF;
        clear   = 8'h00;
        pins3   = 3'b111;
        clear3  = 3'b000;
        step(3);
        chk("rst_level", {24'h0, level}, 32'h0);
        chk("rst_rise",  {24'h0, rise},  32'h0);
        chk("rst_fall",  {24'h0, fall},  32'h0);
        chk("rst_event", {31'h0, evt},   32'h0);
        chk("rst_data",  data,  32'h0);
        chk("rst_data3", data3, 32'h0);

        // Release before edge 1; level must rise on exactly edge 6.
        reset_n = 1'b1;
        step(5);
        chk("lat_level_e5", {24'h0, level}, 32'h00);
        step(1);
        chk("lat_level_e6", {24'h0, level}, 32'hFF);
        chk("lat_rise_e6",  {24'h0, rise},  32'h00);
        step(1);
        chk("lat_rise_e7",  {24'h0, rise},  32'hFF);
        chk("lat_event",    {31'h0, evt},   32'h1);
        chk("lat_data",     data,  32'hFF00FFFF);
        chk("n3_data",      data3, 32'h07000707);
        chk("n3_event",     {31'h0, evt3}, 32'h1);

        clear = 8'hFF;
        step(1);
        clear = 8'h00;
        chk("clrall_rise", {24'h0, rise}, 32'h00);
        chk("clrall_evt",  {31'h0, evt},  32'h0);
        pins = 8'h00;
        step(6);
        chk("drop_level", {24'h0, level}, 32'h00);
        step(1);
        chk("drop_fall",  {24'h0, fall},  32'hFF);
        clear = 8'hFF;
        step(1);
        clear = 8'h00;
        chk("settle_evt", {31'h0, evt}, 32'h0);

        // 3-cycle glitch on channel 3 must be swallowed.
        pins = 8'h08;
        step(3);
        pins = 8'h00;
        step(8);
        chk("glitch_level", {24'h0, level}, 32'h00);
        chk("glitch_rise",  {24'h0, rise},  32'h00);
        chk("glitch_evt",   {31'h0, evt},   32'h0);

        // 4-cycle pulse is just long enough to be accepted, then decays back.
        pins = 8'h08;
        step(4);
        pins = 8'h00;
        step(2);
        chk("p4_level_up",  {24'h0, level}, 32'h08);
        step(1);
        chk("p4_rise",      {24'h0, rise},  32'h08);
        step(2);
        chk("p4_level_e9",  {24'h0, level}, 32'h08);
        step(1);
        chk("p4_level_dn",  {24'h0, level}, 32'h00);
        step(1);
        chk("p4_fall",      {24'h0, fall},  32'h08);
        clear = 8'h08;
        step(1);
        clear = 8'h00;
        chk("p4_clr_evt",   {31'h0, evt},   32'h0);

        // Sustained channel 3: clear only its rise flag, then fall.
        pins = 8'h08;
        step(7);
        chk("c3_rise", {24'h0, rise}, 32'h08);
        clear = 8'h08;
        step(1);
        clear = 8'h00;
        chk("c3_clr_rise",  {24'h0, rise},  32'h00);
        chk("c3_clr_evt",   {31'h0, evt},   32'h0);
        chk("c3_clr_level", {24'h0, level}, 32'h08);
        pins = 8'h00;
        step(7);
        chk("c3_fall",      {24'h0, fall},  32'h08);
        chk("c3_data_fall", {24'h0, data[23:16]}, 32'h08);
        clear = 8'h08;
        step(1);
        clear = 8'h00;

        // Clear asserted during the rise-pulse cycle of channel 5: set wins.
        pins = 8'h20;
        step(6);
        chk("col_level", {24'h0, level}, 32'h20);
        clear = 8'h20;
        step(1);
        clear = 8'h00;
        chk("col_rise",  {24'h0, rise}, 32'h20);
        step(1);
        chk("col_hold",  {24'h0, rise}, 32'h20);

        // Channel 0 toggles; reset lands mid-window after two counted cycles.
        pins = 8'h21;
        step(4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_level", {24'h0, level}, 32'h00);
        chk("arst_rise",  {24'h0, rise},  32'h00);
        chk("arst_data",  data, 32'h0);
        chk("arst_evt",   {31'h0, evt}, 32'h0);
        step(2);
        reset_n = 1'b1;
        step(5);
        chk("arst_lat_e5", {24'h0, level}, 32'h00);
        step(1);
        chk("arst_lat_e6", {24'h0, level}, 32'h21);
        step(1);
        chk("arst_rise_e7", {24'h0, rise}, 32'h21);
        chk("arst_data_e7", data, 32'h21002121);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ext_input_conditioner.md
Name: ext_input_conditioner

Overview:
- Upstream stage for the CPU bus external-data input (`cpubus.external_data_i`) in the board top levels (ECP5 and others).
- Takes raw asynchronous board inputs (buttons, switches, straps) and synchronizes them to `clk_i`.
- Debounces each input with a per-channel counter.
- Detects debounced edges and holds sticky rise/fall flags until firmware clears them.
- Presents a packed 32-bit word for the external data path.

Parameters:
- NUM_INPUTS, 8, number of conditioned inputs; legal range 1..8.
- FPGAClkSpeed, 40000000, clock frequency of `clk_i` in Hz; the top level passes the same value it gives `main_rv32`.
- DEBOUNCE_US, 1000, debounce window in microseconds.
- DEBOUNCE_CYCLES, derived, max(1, (FPGAClkSpeed/1000000)*DEBOUNCE_US); localparam, not overridable.

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  asynchronous, active-low reset (0 = reset asserted).
- pins_i  input  NUM_INPUTS  raw asynchronous board inputs.
- clear_i  input  NUM_INPUTS  one-cycle pulses; bit n clears both sticky flags of channel n.
- level_o  output  NUM_INPUTS  debounced level.
- rise_o  output  NUM_INPUTS  sticky rising-edge flags.
- fall_o  output  NUM_INPUTS  sticky falling-edge flags.
- event_o  output  1  OR of all rise_o and fall_o bits.
- data_o  output  32  packed word for external_data_i.

Behaviour:
- Reset: while reset_i=0, all flops clear asynchronously.
  - Sync stages, counters, level, flags and data_o are 0; event_o=0.
  - Release is taken on the next clk_i edge. Reset mid-debounce discards the count.
- Synchronizer: two flops per channel (sync1, sync2). No logic between them.
- Debounce, per channel, on each clock:
  - If sync2 == level: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: level <= sync2, counter <= 0, one-cycle internal edge pulse.
  - Else: counter <= counter+1.
- Counter behaviour:
  - A glitch shorter than DEBOUNCE_CYCLES cycles resets the count and produces no edge.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1); it never wraps.
- Latency: a clean input transition appears on level_o exactly 2+DEBOUNCE_CYCLES clocks after the first sampling edge.
- Edge detect: rise pulse when level goes 0->1, fall pulse when level goes 1->0, both in the same cycle level updates.
- Sticky flags:
  - An edge pulse sets the flag on the next edge, visible on rise_o/fall_o one cycle after level_o changes.
  - clear_i[n]=1 clears rise_o[n] and fall_o[n].
  - Simultaneous set and clear on the same channel: set wins.
  - Flags are never cleared by anything other than reset_i or clear_i.
- event_o: registered OR; follows flag changes by zero extra cycles (combinational OR of registered flags).
- data_o (combinational from registers), unused high bits within each byte are 0:
  - [7:0] level_o
  - [15:8] rise_o
  - [23:16] fall_o
  - [31:24] sync2 raw levels

Decomposition:
- Package ext_input_package holds:
  - Field offsets EXT_LEVEL_LSB=0, EXT_RISE_LSB=8, EXT_FALL_LSB=16, EXT_RAW_LSB=24.
  - EXT_MAX_INPUTS=8.
  - A function computing DEBOUNCE_CYCLES from clock and microseconds, shared with other timing blocks.
- Sub-module ext_debounce_channel:
  - Covers one channel: synchronizer, counter, level and edge pulse.
  - Parameter DEBOUNCE_CYCLES.
  - The top uses a generate loop and holds the sticky flags and packing.

Test Plan (FPGAClkSpeed=1000000, DEBOUNCE_US=4 -> DEBOUNCE_CYCLES=4):
- Reset: hold reset_i=0 with pins_i=8'hFF, then release -> all outputs 0 during reset. level_o=8'hFF exactly 6 clocks after the first sample; rise_o=8'hFF the following cycle; event_o=1; data_o=32'hFF00FFFF.
- Glitch reject: after settling at 0, pulse pins_i[3]=1 for 3 cycles -> level_o, rise_o and event_o stay 0. A 4-cycle pulse -> level_o[3]=1, then rise_o[3]=1.
- Clear: with rise_o[3]=1, pulse clear_i[3] -> rise_o[3]=0 next cycle; event_o=0; other bits unchanged. Then drop pins_i[3] -> fall_o[3]=1, data_o[23:16]=8'h08.
- Set/clear collision: assert clear_i[5] in the exact cycle channel 5's rise pulse occurs -> rise_o[5]=1 afterward.
- Asynchronous reset mid-debounce: pins_i[0] toggles, reset_i=0 after 2 counted cycles -> all outputs 0 immediately, without waiting for a clock. After release, full 2+4 latency applies again.
- NUM_INPUTS=3 build: drive pins_i=3'b111 -> data_o=32'h07000707 after settle and flag set; bits [7:3] of every field are 0.
